// File: rtl/binary16_accum.sv
// binary16_accum: streaming accumulator for binary16 products.
// Products are queued in a small FIFO and folded into a running sum by an
// iterative align/add/normalize FSM. One sum is emitted per last_in-terminated group.
// Number format: exponent 0 is zero (no subnormals), exponent 31 is infinity, no NaN.
// Optional macro BINARY16_ACCUM_ROUND_EN: round-to-nearest-even at normalize exit
// (otherwise the guard/round/sticky bits are truncated). Latency is the same either way.
//
// state | meaning
// IDLE  | wait for a FIFO entry, pop it into the operand register
// ALIGN | order accumulator/operand by magnitude, right-align the smaller mantissa
// ADD   | add or subtract the aligned mantissas
// NORM  | normalize (1 left shift per cycle), write accumulator, emit on last
module binary16_accum #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic [15:0] data_in,
   input  logic        data_valid_in,
   input  logic        last_in,
   output logic [15:0] result,
   output logic        data_valid_out,
   output logic        overflow,
   output logic        busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

   state_t      state_q, state_d;

   logic [16:0] fifo_mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [16:0] fifo_rdata;
   logic        overflow_q;

   logic [15:0] op_q;
   logic        op_last_q;
   logic [15:0] acc_q;
   logic [15:0] result_q;
   logic        valid_out_q;

   logic [14:0] a_q, b_q, sum_q;
   logic [4:0]  exp_q;
   logic        sign_q, sub_q, inf_q;

   logic        acc_is_big, acc_inf, op_inf;
   logic [15:0] big_w, small_w;
   logic [10:0] big_man, small_man;
   logic [4:0]  exp_diff;
   logic [3:0]  shamt;
   logic [24:0] small_wide;
   logic [14:0] sum_w;

   logic        norm_exit, norm_shift, rnd_up;
   logic [15:0] norm_val;
   logic [10:0] fin_man;
   logic [5:0]  fin_exp, rnd_exp;
   logic [11:0] rnd_man;

   // FIFO status; a full FIFO still accepts a push when it is popped in the same cycle
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
   assign fifo_push  = data_valid_in && (!fifo_full || fifo_pop);
   assign fifo_rdata = fifo_mem_q[rd_ptr_q[AW-1:0]];

   // FIFO storage, {last, data}; contents are don't-care while the pointers say empty
   always_ff @(posedge clk_in) begin
      if (fifo_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {last_in, data_in};
   end

   // FIFO pointers and sticky drop flag
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (data_valid_in && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      end
   end

   // Operand ordering and alignment of the smaller mantissa into {man, g, r, s}
   always_comb begin
      acc_inf    = (acc_q[14:10] == 5'h1F);
      op_inf     = (op_q[14:10] == 5'h1F);
      acc_is_big = (acc_q[14:0] >= op_q[14:0]);
      big_w      = acc_is_big ? acc_q : op_q;
      small_w    = acc_is_big ? op_q : acc_q;
      big_man    = (big_w[14:10] != 5'd0) ? {1'b1, big_w[9:0]} : 11'd0;
      small_man  = (small_w[14:10] != 5'd0) ? {1'b1, small_w[9:0]} : 11'd0;
      exp_diff   = big_w[14:10] - small_w[14:10];
      shamt      = (exp_diff > 5'd14) ? 4'd14 : exp_diff[3:0];
      small_wide = {small_man, 14'd0} >> shamt;
   end

   assign sum_w = sub_q ? (a_q - b_q) : (a_q + b_q);

`ifdef BINARY16_ACCUM_ROUND_EN
   logic [2:0] grs;
   logic       lsb;

   // Round-to-nearest-even decision on the bits below the kept mantissa
   always_comb begin
      if (sum_q[14]) begin
         grs = {sum_q[3], sum_q[2], |sum_q[1:0]};
         lsb = sum_q[4];
      end else begin
         grs = sum_q[2:0];
         lsb = sum_q[3];
      end
      rnd_up = grs[2] & (grs[1] | grs[0] | lsb);
   end
`else
   assign rnd_up = 1'b0;
`endif

   // Normalize step: carry fix-up and exit in one cycle, otherwise one left shift per cycle
   always_comb begin
      norm_exit  = 1'b0;
      norm_shift = 1'b0;
      norm_val   = 16'h0000;
      fin_man    = sum_q[13:3];
      fin_exp    = {1'b0, exp_q};
      rnd_man    = {1'b0, fin_man} + {11'd0, rnd_up};
      rnd_exp    = fin_exp + {5'd0, rnd_man[11]};
      if (inf_q) begin
         norm_exit = 1'b1;
         norm_val  = {sign_q, 5'h1F, 10'h000};
      end else if (sum_q == 15'd0) begin
         norm_exit = 1'b1;
      end else if (sum_q[14] || sum_q[13]) begin
         norm_exit = 1'b1;
         if (sum_q[14]) begin
            fin_man = sum_q[14:4];
            fin_exp = {1'b0, exp_q} + 6'd1;
         end
         rnd_man = {1'b0, fin_man} + {11'd0, rnd_up};
         rnd_exp = fin_exp + {5'd0, rnd_man[11]};
         if (rnd_exp >= 6'd31) norm_val = {sign_q, 5'h1F, 10'h000};
         else norm_val = {sign_q, rnd_exp[4:0], rnd_man[11] ? rnd_man[10:1] : rnd_man[9:0]};
      end else if (exp_q <= 5'd1) begin
         // another left shift would push the exponent below 1: flush to +0
         norm_exit = 1'b1;
      end else begin
         norm_shift = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = ALIGN;
         ALIGN:   state_d = ADD;
         ADD:     state_d = NORM;
         NORM:    if (norm_exit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath registers stepped by the FSM
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= 16'h0000;
         op_last_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         sub_q     <= 1'b0;
         inf_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fifo_pop) begin
                  op_q      <= fifo_rdata[15:0];
                  op_last_q <= fifo_rdata[16];
               end
            end
            ALIGN: begin
               a_q    <= {1'b0, big_man, 3'b000};
               b_q    <= {1'b0, small_wide[24:14], small_wide[13], small_wide[12],
                          |small_wide[11:0]};
               sub_q  <= big_w[15] ^ small_w[15];
               exp_q  <= big_w[14:10];
               inf_q  <= acc_inf | op_inf;
               // an infinite accumulator keeps its sign, covering inf + (-inf)
               sign_q <= acc_inf ? acc_q[15] : (op_inf ? op_q[15] : big_w[15]);
            end
            ADD: begin
               sum_q <= sum_w;
               if (sum_w == 15'd0 && !inf_q) sign_q <= 1'b0;
            end
            NORM: begin
               if (norm_shift) begin
                  sum_q <= sum_q << 1;
                  exp_q <= exp_q - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Accumulator write-back and group emit
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= 16'h0000;
         result_q    <= 16'h0000;
         valid_out_q <= 1'b0;
      end else begin
         valid_out_q <= 1'b0;
         if (state_q == NORM && norm_exit) begin
            if (op_last_q) begin
               result_q    <= norm_val;
               valid_out_q <= 1'b1;
               acc_q       <= 16'h0000;
            end else begin
               acc_q <= norm_val;
            end
         end
      end
   end

   assign result         = result_q;
   assign data_valid_out = valid_out_q;
   assign overflow       = overflow_q;
   assign busy           = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_binary16_accum.sv
// Scoreboard bench for binary16_accum: directed groups push expected sums and
// emit cycles into queues; a monitor pops and compares on each data_valid_out.
module tb_binary16_accum;

   logic        clk_in = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_in = 16'h0000;
   logic        data_valid_in = 1'b0;
   logic        last_in = 1'b0;
   logic [15:0] result;
   logic        data_valid_out;
   logic        overflow;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic dvo_prev = 1'b0;
   logic [15:0] exp_res_q[$];
   int          exp_cyc_q[$];

   binary16_accum #(.FIFO_DEPTH(4)) dut (
      .clk_in(clk_in),
      .rst_n(rst_n),
      .data_in(data_in),
      .data_valid_in(data_valid_in),
      .last_in(last_in),
      .result(result),
      .data_valid_out(data_valid_out),
      .overflow(overflow),
      .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compare every emitted sum against the oldest expectation
   always @(negedge clk_in) begin
      if (rst_n && data_valid_out) begin
         check("dvo_not_back_to_back", {31'd0, dvo_prev}, 32'd0);
         if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_emit: got result %h, required no emit", result);
         end else begin
            check("result", {16'd0, result}, {16'd0, exp_res_q.pop_front()});
            check("emit_cycle", cyc, exp_cyc_q.pop_front());
         end
      end
      dvo_prev <= data_valid_out;
   end

   // Drive one element; for a last element record the expected sum and emit cycle
   task automatic send(input logic [15:0] d, input logic l, input logic [15:0] er, input int lat);
      @(negedge clk_in);
      data_in       = d;
      data_valid_in = 1'b1;
      last_in       = l;
      if (l) begin
         exp_res_q.push_back(er);
         exp_cyc_q.push_back(cyc + 1 + lat);
      end
      @(negedge clk_in);
      data_valid_in = 1'b0;
      last_in       = 1'b0;
      repeat (7) @(negedge clk_in);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      check("reset_result", {16'd0, result}, 32'd0);
      check("reset_dvo", {31'd0, data_valid_out}, 32'd0);
      check("reset_overflow", {31'd0, overflow}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_in);

      send(16'h3C00, 1'b0, 16'h0000, 0);
      send(16'h4000, 1'b1, 16'h4200, 4);
      check("busy_idle_after_group", {31'd0, busy}, 32'd0);

      send(16'h4200, 1'b0, 16'h0000, 0);
      send(16'hC000, 1'b1, 16'h3C00, 5);

      send(16'h7BFF, 1'b0, 16'h0000, 0);
      send(16'h7BFF, 1'b1, 16'h7C00, 4);
      send(16'h0000, 1'b1, 16'h0000, 4);

      send(16'h3C00, 1'b0, 16'h0000, 0);
      send(16'hBC00, 1'b1, 16'h0000, 4);

      send(16'h3C00, 1'b0, 16'h0000, 0);
      send(16'h1000, 1'b1, 16'h3C00, 4);

      send(16'hC000, 1'b0, 16'h0000, 0);
      send(16'h3C00, 1'b1, 16'hBC00, 5);

      send(16'h7C00, 1'b0, 16'h0000, 0);
      send(16'hFC00, 1'b1, 16'h7C00, 4);

      send(16'hFC00, 1'b0, 16'h0000, 0);
      send(16'h3C00, 1'b1, 16'hFC00, 4);

      send(16'h0401, 1'b0, 16'h0000, 0);
      send(16'h8400, 1'b1, 16'h0000, 4);

      send(16'h3C00, 1'b0, 16'h0000, 0);
      send(16'h3C00, 1'b0, 16'h0000, 0);
      send(16'h3C00, 1'b1, 16'h4200, 4);

      send(16'h3C00, 1'b0, 16'h0000, 0);
      send(16'h3800, 1'b1, 16'h3E00, 4);

      check("result_held", {16'd0, result}, 32'h3E00);
      check("overflow_clear_before_burst", {31'd0, overflow}, 32'd0);

      // 8 back-to-back pushes into a depth-4 FIFO: 6 accepted, 7th dropped
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_in);
         if (i == 6) check("overflow_after_6", {31'd0, overflow}, 32'd0);
         if (i == 7) check("overflow_after_7", {31'd0, overflow}, 32'd1);
         data_in       = 16'h3C00;
         data_valid_in = 1'b1;
         last_in       = 1'b0;
      end
      @(negedge clk_in);
      data_valid_in = 1'b0;
      check("overflow_sticky", {31'd0, overflow}, 32'd1);
      repeat (2) @(negedge clk_in);
      check("busy_mid_group", {31'd0, busy}, 32'd1);

      rst_n = 1'b0;
      #1;
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_dvo", {31'd0, data_valid_out}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk_in);
      rst_n = 1'b1;
      repeat (6) @(negedge clk_in);
      check("fifo_empty_after_rst", {31'd0, busy}, 32'd0);

      send(16'h4000, 1'b1, 16'h4000, 4);
      repeat (4) @(negedge clk_in);
      check("all_emits_seen", exp_res_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
